alu_muldiv_seq: RTL and testbench
=================================

// Module: alu_muldiv_seq
// PURPOSE
//  Multi-cycle unsigned MUL/MULHU/DIVU/REMU unit for the EX stage. Sequences one
//  internal instance of the shared 32-bit ALU (ADD/SUB) over 32 iterations.
//  Takes requests from the decode/EX path over valid/ready and returns a single
//  32-bit result over valid/ready. Keeps multiply/divide hardware off the main ALU.
// PARAMETERS
//  XLEN   32  operand/result width; only 32 is supported
//  ITERS  32  iteration count; must equal XLEN
// PORTS
//  clk         in   1   single clock; all state updates on the posedge
//  rst         in   1   reset, synchronous, active-high
//  req_valid   in   1   request present
//  req_ready   out  1   unit can accept (high only in IDLE)
//  req_op      in   2   `MD_MUL=0 `MD_MULHU=1 `MD_DIVU=2 `MD_REMU=3
//  req_a       in   32  multiplier / dividend
//  req_b       in   32  multiplicand / divisor
//  resp_valid  out  1   result present; held until accepted
//  resp_ready  in   1   consumer accepts result
//  resp_data   out  32  result
//  busy        out  1   high in RUN or DONE
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, req_ready=1, resp_valid=0, resp_data=0,
//   busy=0, iteration counter=0. Reset mid-operation discards all work; no response.
//  FSM: IDLE -(req_valid&req_ready)-> RUN, or -> DONE if op is DIVU/REMU and b==0.
//   RUN  -(counter==ITERS-1 at the edge)-> DONE; counter increments once per cycle.
//   DONE -(resp_valid&resp_ready)-> IDLE. Ready is never asserted in RUN or DONE.
//  Latency: with acceptance at edge T, resp_valid rises after edge T+32. With
//   divide-by-zero, it rises after edge T+1. The next request is accepted no earlier
//   than the cycle after the response handshake.
//  Capture at acceptance: op, a, b latched. Later changes on req_* are ignored.
//  Multiply (shift-add): hi=0, lo=a, M=b. Each iteration drives ALU A=hi,
//   B=lo[0]?M:0, op=`ADD. carry=(sum<hi), unsigned compare.
//   {hi,lo} <= {carry,sum,lo[31:1]}. At the end: MUL returns lo, MULHU returns hi.
//  Divide (restoring): R=0, Q=a, D=b. Each iteration: c=R[31], Rs={R[30:0],Q[31]}.
//   Drive ALU A=Rs, B=D, op=`SUB. If c | (Rs>=D): R<=diff and Q<={Q[30:0],1};
//   otherwise R<=Rs and Q<={Q[30:0],0}. At the end: DIVU returns Q, REMU returns R.
//  Divide by zero (RISC-V semantics): DIVU returns 32'hFFFFFFFF; REMU returns a.
//   The ALU is not stepped in this case.
//  resp_data is registered on entry to DONE. It and resp_valid stay stable while
//   resp_ready is low.
//  ALU Unsigned input is tied to signed-mode so ADD/SUB are unaffected.
//  Carry-out is not taken from the ALU; it is recomputed externally as above.
//  b==0 with MUL/MULHU takes the normal 32-cycle path and returns 0.
//  The full 32 iterations always run; there is no early termination.
// STRUCTURE
//  param.v gains the op encodings (`MD_MUL, `MD_MULHU, `MD_DIVU, `MD_REMU) and the
//   state encodings (`MD_IDLE, `MD_RUN, `MD_DONE). ALU op codes come from there too.
//  One sub-module: the existing ALU, instanced once, driven by the datapath muxes.
//  Everything else (FSM, 5-bit counter, hi/lo/R/Q registers) is flat in this module.
// TESTING
//  1 MUL a=7 b=6 -> resp_data=42, resp_valid exactly 32 cycles after accept.
//  2 MULHU a=b=32'hFFFFFFFF -> 32'hFFFFFFFE; MUL with the same operands -> 32'h00000001.
//  3 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 32'hFFFFFFFF/1 -> 32'hFFFFFFFF.
//  4 DIVU a=123 b=0 -> 32'hFFFFFFFF; REMU a=123 b=0 -> 123; both with resp_valid
//    1 cycle after accept.
//  5 Backpressure: hold resp_ready=0 for 5 cycles in DONE -> resp_valid/resp_data
//    stable and req_ready=0. Drive a new request in that window -> not accepted.
//  6 rst=1 during iteration 10 -> next cycle IDLE, req_ready=1, resp_valid=0, busy=0.
//    A fresh MUL 3*5 then returns 15.

Source files
------------

// File: rtl/alu_muldiv_seq_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
//   XLEN / ITERS : datapath width and iteration count (both fixed at 32)
//   md_op_e      : request operation encoding
//   md_state_e   : control FSM state encoding
//   alu_op_e     : op select of the shared ADD/SUB ALU
package alu_muldiv_seq_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITERS = 32;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    MD_MUL   = 2'd0,
    MD_MULHU = 2'd1,
    MD_DIVU  = 2'd2,
    MD_REMU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_SLT = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_e;

  // Request payload as seen at the input handshake
  typedef struct packed {
    md_op_e            op;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
  } md_req_t;

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIVU) || (op == MD_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_seq_alu.sv
// Shared integer ALU (combinational).
//   op          : ALU_ADD / ALU_SUB / ALU_SLT / ALU_XOR
//   unsigned_i  : selects unsigned compare for SLT; ADD/SUB ignore it
//   a, b        : operands
//   y           : result
module alu_muldiv_seq_alu
  import alu_muldiv_seq_pkg::*;
(
  input  alu_op_e         op,
  input  logic            unsigned_i,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  logic lt;

  // Result select
  always_comb begin
    y  = '0;
    lt = unsigned_i ? (a < b) : ($signed(a) < $signed(b));
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_SLT: y = XLEN'(lt);
      ALU_XOR: y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU unit. Steps one shared ALU through
// 32 shift-add (multiply) or restoring-subtract (divide) iterations.
//   clk, rst               : clock, synchronous active-high reset
//   req_valid/ready        : request handshake; ready only while idle
//   req_op, req_a, req_b   : operation, multiplier/dividend, multiplicand/divisor
//   resp_valid/ready       : response handshake; result held until accepted
//   resp_data              : 32-bit result
//   busy                   : operation in flight or result pending
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  md_state_e        state_q, state_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic             busy_q, busy_d;
  logic [XLEN-1:0]  resp_data_q, resp_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_e           op_q, op_d;
  logic [XLEN-1:0]  opnd_q, opnd_d;   // multiplicand M / divisor D
  logic [XLEN-1:0]  acc_q, acc_d;     // hi / partial remainder R
  logic [XLEN-1:0]  sh_q, sh_d;       // lo / quotient Q

  md_req_t          req;
  logic             accept, resp_fire, last_iter, div_zero;
  logic [XLEN-1:0]  alu_a, alu_b, alu_y, rs;
  alu_op_e          alu_op;
  logic             carry;

  assign req        = '{op: md_op_e'(req_op), a: req_a, b: req_b};
  assign accept     = req_valid & req_ready_q;
  assign resp_fire  = resp_valid_q & resp_ready;
  assign last_iter  = (cnt_q == CNT_W'(ITERS - 1));
  assign div_zero   = md_is_div(req.op) && (req.b == '0);
  assign rs         = {acc_q[XLEN-2:0], sh_q[XLEN-1]};

  alu_muldiv_seq_alu u_alu (
    .op         (alu_op),
    .unsigned_i (1'b0),
    .a          (alu_a),
    .b          (alu_b),
    .y          (alu_y)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= MD_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (accept)    state_d = div_zero ? MD_DONE : MD_RUN;
      MD_RUN:  if (last_iter) state_d = MD_DONE;
      MD_DONE: if (resp_fire) state_d = MD_IDLE;
      default:                state_d = MD_IDLE;
    endcase
  end

  // Handshake/status outputs. A divide-by-zero enters DONE straight from IDLE;
  // its valid is held back one cycle so the response appears one cycle after accept.
  always_comb begin
    req_ready_d  = (state_d == MD_IDLE);
    busy_d       = (state_d != MD_IDLE);
    resp_valid_d = (state_d == MD_DONE) && (state_q != MD_IDLE);
  end

  // ALU operand muxing: shift-add for multiply, restoring subtract for divide
  always_comb begin
    if (md_is_div(op_q)) begin
      alu_a  = rs;
      alu_b  = opnd_q;
      alu_op = ALU_SUB;
    end else begin
      alu_a  = acc_q;
      alu_b  = sh_q[0] ? opnd_q : '0;
      alu_op = ALU_ADD;
    end
  end

  // Datapath next-state
  always_comb begin
    cnt_d       = cnt_q;
    op_d        = op_q;
    opnd_d      = opnd_q;
    acc_d       = acc_q;
    sh_d        = sh_q;
    resp_data_d = resp_data_q;
    carry       = (alu_y < acc_q);
    case (state_q)
      MD_IDLE: begin
        if (accept) begin
          op_d   = req.op;
          opnd_d = req.b;
          acc_d  = '0;
          sh_d   = req.a;
          cnt_d  = '0;
          if (div_zero)
            resp_data_d = (req.op == MD_DIVU) ? '1 : req.a;
        end
      end
      MD_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (md_is_div(op_q)) begin
          // Bit shifted out of R means the shifted remainder already exceeds D
          if (acc_q[XLEN-1] || (rs >= opnd_q)) begin
            acc_d = alu_y;
            sh_d  = {sh_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = rs;
            sh_d  = {sh_q[XLEN-2:0], 1'b0};
          end
        end else begin
          acc_d = {carry, alu_y[XLEN-1:1]};
          sh_d  = {alu_y[0], sh_q[XLEN-1:1]};
        end
        if (last_iter)
          resp_data_d = ((op_q == MD_MUL) || (op_q == MD_DIVU)) ? sh_d : acc_d;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      resp_data_q  <= '0;
      cnt_q        <= '0;
      op_q         <= MD_MUL;
      opnd_q       <= '0;
      acc_q        <= '0;
      sh_q         <= '0;
    end else begin
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
      resp_data_q  <= resp_data_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      opnd_q       <= opnd_d;
      acc_q        <= acc_d;
      sh_q         <= sh_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed vector table, randomized
// operations against an arithmetic reference, backpressure and mid-run reset.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  alu_muldiv_seq dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic with RISC-V divide-by-zero results
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and return after the accepting edge (#1 later)
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    chk("req_ready_before_accept", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    tick();
    req_valid = 1'b0;
    req_op    = 2'($urandom_range(0, 3));
    req_a     = $urandom;
    req_b     = $urandom;
  endtask

  // Count cycles from acceptance until resp_valid, bounded
  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!resp_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL resp_timeout: no resp_valid after %0d cycles", lat);
    end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    start_op(op, a, b);
    chk({name, "_busy"}, 32'(busy), 32'd1);
    wait_resp(lat);
    chk({name, "_data"}, resp_data, exp);
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
    finish_resp();
    chk({name, "_valid_drop"}, 32'(resp_valid), 32'd0);
    chk({name, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int lat;
    logic [1:0]  op;
    logic [31:0] a, b;

    vecs[0] = '{op: 2'd0, a: 32'd7,          b: 32'd6,          exp: 32'd42,         lat: 32};
    vecs[1] = '{op: 2'd1, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, exp: 32'hFFFF_FFFE, lat: 32};
    vecs[2] = '{op: 2'd0, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, exp: 32'h0000_0001, lat: 32};
    vecs[3] = '{op: 2'd2, a: 32'd100,        b: 32'd7,          exp: 32'd14,         lat: 32};
    vecs[4] = '{op: 2'd3, a: 32'd100,        b: 32'd7,          exp: 32'd2,          lat: 32};
    vecs[5] = '{op: 2'd2, a: 32'hFFFF_FFFF, b: 32'd1,          exp: 32'hFFFF_FFFF, lat: 32};
    vecs[6] = '{op: 2'd2, a: 32'd123,        b: 32'd0,          exp: 32'hFFFF_FFFF, lat: 1};
    vecs[7] = '{op: 2'd3, a: 32'd123,        b: 32'd0,          exp: 32'd123,        lat: 1};

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = 2'd0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_req_ready",  32'(req_ready),  32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_resp_data",  resp_data,       32'd0);

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // MUL by zero takes the full path
    run_op("mul_b0", 2'd0, 32'h1234_5678, 32'd0, 32'd0, 32);

    // Randomized operations against the reference
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 15));
      run_op($sformatf("rand%0d", i), op, a, b, model(op, a, b),
             (op >= 2'd2 && b == 0) ? 1 : 32);
    end

    // Backpressure: result held, no new request accepted while pending
    start_op(2'd0, 32'd9, 32'd9);
    wait_resp(lat);
    req_valid = 1'b1;
    req_op    = 2'd0;
    req_a     = 32'd2;
    req_b     = 32'd2;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid",     32'(resp_valid), 32'd1);
      chk("bp_data",      resp_data,       32'd81);
      chk("bp_req_ready", 32'(req_ready),  32'd0);
      tick();
    end
    req_valid = 1'b0;
    finish_resp();
    chk("bp_idle_busy",  32'(busy),       32'd0);
    chk("bp_idle_ready", 32'(req_ready),  32'd1);
    tick();
    chk("bp_no_extra_valid", 32'(resp_valid), 32'd0);
    chk("bp_no_extra_busy",  32'(busy),       32'd0);

    // Reset in the middle of an operation
    start_op(2'd0, 32'hDEAD_BEEF, 32'h0000_1234);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_req_ready",  32'(req_ready),  32'd1);
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_busy",       32'(busy),       32'd0);
    repeat (40) tick();
    chk("mid_rst_no_resp", 32'(resp_valid), 32'd0);
    run_op("post_rst_mul", 2'd0, 32'd3, 32'd5, 32'd15, 32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
